// File: rtl/systolic_pkg.sv
// Shared types and width helpers for the systolic tile controller,
// the operand scheduler and the array top.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } ctrl_state_t;

  // Step counter holds K + 2N - 1 for any K < 2^aw and N <= 2^aw.
  function automatic int step_count_width(input int addr_width);
    return addr_width + 2;
  endfunction

  // Phase counter width; a single bit even when every cycle is a step.
  function automatic int phase_count_width(input int mac_latency);
    return (mac_latency > 1) ? $clog2(mac_latency) : 1;
  endfunction

endpackage

// File: rtl/sa_skew_shreg.sv
// N-tap skew shift register: tap i holds the issue bit delayed by i steps.
// Advances only on step pulses; clear wins over shift.
module sa_skew_shreg #(
  parameter int TAPS = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            shift,
  input  logic            din,
  output logic [TAPS-1:0] taps
);

  // Shift one tap per step, new bit enters at tap 0.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      taps <= '0;
    end else if (shift) begin
      taps <= (taps << 1) | TAPS'(din);
    end
  end

endmodule

// File: rtl/systolic_tile_controller.sv
// Sequences one systolic matrix op: weight load (N cycles), skewed activation
// streaming over K + 2N - 1 steps of MAC_LATENCY cycles each, then a done pulse.
//
// state  | meaning
// IDLE   | waiting for a command, ready=1
// LOAD_W | weight rows 0..N-1 loaded, one per cycle
// STREAM | activations fed and results captured, strobes on phase 0 only
// DONE   | single-cycle completion pulse
module systolic_tile_controller
  import systolic_pkg::*;
#(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32,
  parameter int MAC_LATENCY = 4,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  num_rows,
  input  logic                   abort,
  output logic                   ready,
  output logic                   busy,
  output logic                   cmd_err,
  output logic [MATRIX_SIZE-1:0] load_weight,
  output logic [ADDR_WIDTH-1:0]  w_rd_addr,
  output logic [MATRIX_SIZE-1:0] enable_mult,
  output logic                   act_rd_en,
  output logic [ADDR_WIDTH-1:0]  act_rd_addr,
  output logic [MATRIX_SIZE-1:0] feed_valid,
  output logic [MATRIX_SIZE-1:0] result_valid,
  output logic                   done
);

  localparam int N  = MATRIX_SIZE;
  localparam int SW = step_count_width(ADDR_WIDTH);
  localparam int PW = phase_count_width(MAC_LATENCY);

  localparam logic [PW-1:0]         PHASE_LAST = PW'(MAC_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_LAST   = ADDR_WIDTH'(N - 1);
  localparam logic [SW-1:0]         SKEW_STEPS = SW'(2 * N - 1);

  // DATA_SIZE only sizes the datapath elsewhere; reject nonsense at elaboration.
  if (MATRIX_SIZE < 2 || MAC_LATENCY < 1 || DATA_SIZE < 1) begin : g_bad_param
    $error("systolic_tile_controller: illegal parameter set");
  end

  ctrl_state_t state, state_next;

  logic [PW-1:0]         phase;
  logic [SW-1:0]         step;
  logic [SW-1:0]         step_total;
  logic [ADDR_WIDTH-1:0] row;
  logic [ADDR_WIDTH-1:0] k_rows;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [N-1:0]          feed_taps;
  logic [N-1:0]          result_taps;

  logic accept;
  logic phase_wrap;
  logic last_step;
  logic phase_zero;
  logic issue_next;
  logic skew_shift;
  logic skew_clear;

  assign accept     = (state == IDLE) && start && (num_rows != '0);
  assign phase_wrap = (state == STREAM) && (phase == PHASE_LAST);
  assign last_step  = (step == step_total - SW'(1));
  assign phase_zero = (state == STREAM) && (phase == '0);

  // Taps describe the step currently in progress, so they are loaded at the
  // edge that starts a step: vector 0 enters as LOAD_W ends, vector s+1 enters
  // at the wrap out of step s while s+1 < K.
  assign issue_next = (state == LOAD_W) ? 1'b1 : ((step + SW'(1)) < {2'b00, k_rows});
  assign skew_shift = ((state == LOAD_W) && (row == ROW_LAST)) || phase_wrap;
  assign skew_clear = (state == IDLE) || (state == DONE) || abort;

  sa_skew_shreg #(.TAPS(N)) u_feed_skew (
    .clk   (clk),
    .reset (reset),
    .clear (skew_clear),
    .shift (skew_shift),
    .din   (issue_next),
    .taps  (feed_taps)
  );

  // Result column 0 trails feed row N-1 by one step, i.e. vector k at step k+N.
  sa_skew_shreg #(.TAPS(N)) u_result_skew (
    .clk   (clk),
    .reset (reset),
    .clear (skew_clear),
    .shift (skew_shift),
    .din   (feed_taps[N-1]),
    .taps  (result_taps)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_next   = state;
    ready        = 1'b0;
    busy         = 1'b0;
    load_weight  = '0;
    w_rd_addr    = '0;
    enable_mult  = '0;
    act_rd_en    = 1'b0;
    act_rd_addr  = addr_hold;
    feed_valid   = '0;
    result_valid = '0;
    done         = 1'b0;

    case (state)
      IDLE: begin
        ready = 1'b1;
        if (accept) state_next = LOAD_W;
      end
      LOAD_W: begin
        busy        = 1'b1;
        load_weight = '1;
        w_rd_addr   = row;
        if (row == ROW_LAST) state_next = STREAM;
      end
      STREAM: begin
        busy        = 1'b1;
        enable_mult = '1;
        if (phase_zero) begin
          act_rd_en    = feed_taps[0];
          feed_valid   = feed_taps;
          result_valid = result_taps;
        end
        if (act_rd_en) act_rd_addr = step[ADDR_WIDTH-1:0];
        if (phase_wrap && last_step) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Abort is a no-op in IDLE so a same-cycle start still wins there.
    if (abort && (state != IDLE)) state_next = IDLE;
  end

  // Command latch, row/phase/step counters, address hold and error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      k_rows     <= '0;
      step_total <= '0;
      row        <= '0;
      phase      <= '0;
      step       <= '0;
      addr_hold  <= '0;
      cmd_err    <= 1'b0;
    end else begin
      cmd_err   <= (state == IDLE) && start && (num_rows == '0);
      addr_hold <= act_rd_addr;

      if (accept) begin
        k_rows     <= num_rows;
        step_total <= {2'b00, num_rows} + SKEW_STEPS;
      end

      if ((state == LOAD_W) && (state_next == LOAD_W)) begin
        row <= row + ADDR_WIDTH'(1);
      end else begin
        row <= '0;
      end

      if ((state == STREAM) && (state_next == STREAM)) begin
        if (phase_wrap) begin
          phase <= '0;
          step  <= step + SW'(1);
        end else begin
          phase <= phase + PW'(1);
        end
      end else begin
        phase <= '0;
        step  <= '0;
      end
    end
  end

endmodule
